// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the core load/store
// path and the host/debug port.
//
// Core has default priority. A starvation counter lets the host win a conflict
// once it has lost HOST_MAX_WAIT consecutive conflicts. Read data returns one
// cycle after issue, qualified by the rvalid of whoever issued the read.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   core_read/core_write       core load/store request
//   core_byte_en               core byte store qualifier (bits [7:0] only)
//   core_addr/core_wdata       core address and store data
//   core_stall                 core request present but not granted
//   core_rdata/core_rvalid     core load data and its qualifier
//   host_req/host_we           host request, 1 = write
//   host_addr/host_wdata       host address and write data
//   host_gnt                   host request accepted this cycle
//   host_rdata/host_rvalid     host read data and its qualifier
//   mem_addr/mem_wdata         memory address and write data
//   mem_we/mem_byte_en         memory write strobe and byte qualifier
//   mem_rdata                  memory read data, valid the cycle after the address
module dmem_arbiter #(
  parameter int unsigned DATA_WIDTH    = 20,
  parameter int unsigned ADDRESS_WIDTH = 8,
  parameter int unsigned HOST_MAX_WAIT = 4,
  parameter int unsigned WAIT_WIDTH    = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     core_read,
  input  logic                     core_write,
  input  logic                     core_byte_en,
  input  logic [ADDRESS_WIDTH-1:0] core_addr,
  input  logic [DATA_WIDTH-1:0]    core_wdata,
  output logic                     core_stall,
  output logic [DATA_WIDTH-1:0]    core_rdata,
  output logic                     core_rvalid,
  input  logic                     host_req,
  input  logic                     host_we,
  input  logic [ADDRESS_WIDTH-1:0] host_addr,
  input  logic [DATA_WIDTH-1:0]    host_wdata,
  output logic                     host_gnt,
  output logic [DATA_WIDTH-1:0]    host_rdata,
  output logic                     host_rvalid,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  output logic                     mem_we,
  output logic                     mem_byte_en,
  input  logic [DATA_WIDTH-1:0]    mem_rdata
);

  localparam logic [WAIT_WIDTH-1:0] MaxWait = WAIT_WIDTH'(HOST_MAX_WAIT);

  typedef enum logic [1:0] {OwnNone, OwnCore, OwnHost} own_e;

  own_e                  rd_own_q, rd_own_d;
  logic [WAIT_WIDTH-1:0] wait_cnt_q, wait_cnt_d;

  logic core_req;
  logic core_sel;
  logic host_sel;
  logic host_priority;

  // The counter saturates at MaxWait, so equality is the same as ">=" here and
  // stays meaningful when HOST_MAX_WAIT is 0 (host always wins).
  assign host_priority = (wait_cnt_q == MaxWait);

  always_comb begin
    core_req = core_read | core_write;
    core_sel = 1'b0;
    host_sel = 1'b0;
    if (!rst) begin
      if (core_req && host_req) begin
        if (host_priority) host_sel = 1'b1;
        else               core_sel = 1'b1;
      end else if (core_req) begin
        core_sel = 1'b1;
      end else if (host_req) begin
        host_sel = 1'b1;
      end
    end

    core_stall = core_req & ~core_sel & ~rst;
    host_gnt   = host_sel;

    mem_addr    = '0;
    mem_wdata   = '0;
    mem_we      = 1'b0;
    mem_byte_en = 1'b0;
    if (core_sel) begin
      mem_addr    = core_addr;
      mem_wdata   = core_wdata;
      mem_we      = core_write;
      mem_byte_en = core_byte_en;
    end else if (host_sel) begin
      mem_addr    = host_addr;
      mem_wdata   = host_wdata;
      mem_we      = host_we;
    end

    // Read+write together is treated as a write only: no read owner recorded.
    rd_own_d = OwnNone;
    if (core_sel && core_read && !core_write) rd_own_d = OwnCore;
    else if (host_sel && !host_we)            rd_own_d = OwnHost;

    wait_cnt_d = wait_cnt_q;
    if (host_sel)                                wait_cnt_d = '0;
    else if (host_req && (wait_cnt_q != MaxWait)) wait_cnt_d = wait_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_own_q   <= OwnNone;
      wait_cnt_q <= '0;
    end else begin
      rd_own_q   <= rd_own_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Gating with rst drops the response of a read issued just before reset.
  assign core_rvalid = (rd_own_q == OwnCore) & ~rst;
  assign host_rvalid = (rd_own_q == OwnHost) & ~rst;
  assign core_rdata  = mem_rdata;
  assign host_rdata  = mem_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic mem_init;

  // DUT0: HOST_MAX_WAIT = 4
  logic        rst, core_read, core_write, core_byte_en, host_req, host_we;
  logic [7:0]  core_addr, host_addr, mem_addr;
  logic [19:0] core_wdata, host_wdata, mem_wdata, mem_rdata, core_rdata, host_rdata;
  logic        core_stall, core_rvalid, host_gnt, host_rvalid, mem_we, mem_byte_en;

  // DUT1: HOST_MAX_WAIT = 0
  logic        rst1, core_read1, core_write1, core_byte_en1, host_req1, host_we1;
  logic [7:0]  core_addr1, host_addr1, mem_addr1;
  logic [19:0] core_wdata1, host_wdata1, mem_wdata1, mem_rdata1, core_rdata1, host_rdata1;
  logic        core_stall1, core_rvalid1, host_gnt1, host_rvalid1, mem_we1, mem_byte_en1;

  dmem_arbiter #(.DATA_WIDTH(20), .ADDRESS_WIDTH(8), .HOST_MAX_WAIT(4), .WAIT_WIDTH(3)) dut (
    .clk(clk), .rst(rst),
    .core_read(core_read), .core_write(core_write), .core_byte_en(core_byte_en),
    .core_addr(core_addr), .core_wdata(core_wdata), .core_stall(core_stall),
    .core_rdata(core_rdata), .core_rvalid(core_rvalid),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_gnt(host_gnt), .host_rdata(host_rdata),
    .host_rvalid(host_rvalid),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_byte_en(mem_byte_en), .mem_rdata(mem_rdata)
  );

  dmem_arbiter #(.DATA_WIDTH(20), .ADDRESS_WIDTH(8), .HOST_MAX_WAIT(0), .WAIT_WIDTH(3)) dut1 (
    .clk(clk), .rst(rst1),
    .core_read(core_read1), .core_write(core_write1), .core_byte_en(core_byte_en1),
    .core_addr(core_addr1), .core_wdata(core_wdata1), .core_stall(core_stall1),
    .core_rdata(core_rdata1), .core_rvalid(core_rvalid1),
    .host_req(host_req1), .host_we(host_we1), .host_addr(host_addr1),
    .host_wdata(host_wdata1), .host_gnt(host_gnt1), .host_rdata(host_rdata1),
    .host_rvalid(host_rvalid1),
    .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_we(mem_we1),
    .mem_byte_en(mem_byte_en1), .mem_rdata(mem_rdata1)
  );

  function automatic logic [19:0] preload(input int a);
    case (a)
      1:       return 20'h11111;
      2:       return 20'h22222;
      5:       return 20'h55555;
      32:      return 20'h12345;
      default: return 20'h00000;
    endcase
  endfunction

  // Synchronous single-port memory models, read-before-write.
  logic [19:0] mem0 [256];
  logic [19:0] mem1 [256];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem0[i] <= preload(i);
    end else begin
      if (mem_we) begin
        if (mem_byte_en) mem0[mem_addr][7:0] <= mem_wdata[7:0];
        else             mem0[mem_addr] <= mem_wdata;
      end
      mem_rdata <= mem0[mem_addr];
    end
  end

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem1[i] <= preload(i);
    end else begin
      if (mem_we1) begin
        if (mem_byte_en1) mem1[mem_addr1][7:0] <= mem_wdata1[7:0];
        else              mem1[mem_addr1] <= mem_wdata1;
      end
      mem_rdata1 <= mem1[mem_addr1];
    end
  end

  typedef struct {
    logic        r;
    logic        crd, cwr, cbe;
    logic [7:0]  caddr;
    logic [19:0] cwd;
    logic        hreq, hwe;
    logic [7:0]  haddr;
    logic [19:0] hwd;
    logic        e_stall, e_gnt, e_we, e_be;
    logic [7:0]  e_addr;
    logic [19:0] e_wd;
    logic        e_crv, e_hrv;
    logic [19:0] e_rd;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic add(input logic r, input logic crd, input logic cwr, input logic cbe,
                     input logic [7:0] caddr, input logic [19:0] cwd,
                     input logic hreq, input logic hwe, input logic [7:0] haddr,
                     input logic [19:0] hwd,
                     input logic e_stall, input logic e_gnt, input logic e_we,
                     input logic e_be, input logic [7:0] e_addr, input logic [19:0] e_wd,
                     input logic e_crv, input logic e_hrv, input logic [19:0] e_rd);
    vec_t v;
    v.r = r; v.crd = crd; v.cwr = cwr; v.cbe = cbe; v.caddr = caddr; v.cwd = cwd;
    v.hreq = hreq; v.hwe = hwe; v.haddr = haddr; v.hwd = hwd;
    v.e_stall = e_stall; v.e_gnt = e_gnt; v.e_we = e_we; v.e_be = e_be;
    v.e_addr = e_addr; v.e_wd = e_wd; v.e_crv = e_crv; v.e_hrv = e_hrv; v.e_rd = e_rd;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h, expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    rst = v.r; core_read = v.crd; core_write = v.cwr; core_byte_en = v.cbe;
    core_addr = v.caddr; core_wdata = v.cwd;
    host_req = v.hreq; host_we = v.hwe; host_addr = v.haddr; host_wdata = v.hwd;
  endtask

  task automatic check(input int i, input vec_t v);
    chk("core_stall", i, 32'(core_stall), 32'(v.e_stall));
    chk("host_gnt", i, 32'(host_gnt), 32'(v.e_gnt));
    chk("mem_we", i, 32'(mem_we), 32'(v.e_we));
    chk("mem_byte_en", i, 32'(mem_byte_en), 32'(v.e_be));
    chk("mem_addr", i, 32'(mem_addr), 32'(v.e_addr));
    chk("mem_wdata", i, 32'(mem_wdata), 32'(v.e_wd));
    chk("core_rvalid", i, 32'(core_rvalid), 32'(v.e_crv));
    chk("host_rvalid", i, 32'(host_rvalid), 32'(v.e_hrv));
    if (v.e_crv) chk("core_rdata", i, 32'(core_rdata), 32'(v.e_rd));
    if (v.e_hrv) chk("host_rdata", i, 32'(host_rdata), 32'(v.e_rd));
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    mem_init = 1'b1;
    rst = 1'b1; core_read = 0; core_write = 0; core_byte_en = 0; core_addr = 0;
    core_wdata = 0; host_req = 0; host_we = 0; host_addr = 0; host_wdata = 0;
    rst1 = 1'b1; core_read1 = 0; core_write1 = 0; core_byte_en1 = 0; core_addr1 = 0;
    core_wdata1 = 0; host_req1 = 0; host_we1 = 0; host_addr1 = 0; host_wdata1 = 0;

    //  r  crd cwr cbe caddr  cwd          hreq hwe haddr hwd
    //     stall gnt we be e_addr e_wd      crv hrv rd
    // reset holds off all grants even with requests present
    add(1, 0,1,0,8'h30,20'h77777, 1,0,8'h05,20'h0, 0,0,0,0,8'h00,20'h0, 0,0,20'h0);
    add(1, 0,0,0,8'h00,20'h0,     0,0,8'h00,20'h0, 0,0,0,0,8'h00,20'h0, 0,0,20'h0);
    // core store then load
    add(0, 0,1,0,8'h10,20'h0ABCD, 0,0,8'h00,20'h0, 0,0,1,0,8'h10,20'h0ABCD, 0,0,20'h0);
    add(0, 1,0,0,8'h10,20'h0,     0,0,8'h00,20'h0, 0,0,0,0,8'h10,20'h0, 0,0,20'h0);
    add(0, 0,0,0,8'h00,20'h0,     0,0,8'h00,20'h0, 0,0,0,0,8'h00,20'h0, 1,0,20'h0ABCD);
    // byte store onto preloaded 0x12345
    add(0, 0,1,1,8'h20,20'hFFF5A, 0,0,8'h00,20'h0, 0,0,1,1,8'h20,20'hFFF5A, 0,0,20'h0);
    add(0, 1,0,0,8'h20,20'h0,     0,0,8'h00,20'h0, 0,0,0,0,8'h20,20'h0, 0,0,20'h0);
    add(0, 0,0,0,8'h00,20'h0,     0,0,8'h00,20'h0, 0,0,0,0,8'h00,20'h0, 1,0,20'h1235A);
    // interleaved core/host reads
    add(0, 1,0,0,8'h01,20'h0,     0,0,8'h00,20'h0, 0,0,0,0,8'h01,20'h0, 0,0,20'h0);
    add(0, 0,0,0,8'h00,20'h0,     1,0,8'h02,20'h0, 0,1,0,0,8'h02,20'h0, 1,0,20'h11111);
    add(0, 0,0,0,8'h00,20'h0,     0,0,8'h00,20'h0, 0,0,0,0,8'h00,20'h0, 0,1,20'h22222);
    // starvation: host loses four conflicts, wins the fifth
    add(0, 1,0,0,8'h01,20'h0,     1,0,8'h05,20'h0, 0,0,0,0,8'h01,20'h0, 0,0,20'h0);
    add(0, 1,0,0,8'h01,20'h0,     1,0,8'h05,20'h0, 0,0,0,0,8'h01,20'h0, 1,0,20'h11111);
    add(0, 1,0,0,8'h01,20'h0,     1,0,8'h05,20'h0, 0,0,0,0,8'h01,20'h0, 1,0,20'h11111);
    add(0, 1,0,0,8'h01,20'h0,     1,0,8'h05,20'h0, 0,0,0,0,8'h01,20'h0, 1,0,20'h11111);
    add(0, 1,0,0,8'h01,20'h0,     1,0,8'h05,20'h0, 1,1,0,0,8'h05,20'h0, 1,0,20'h11111);
    add(0, 1,0,0,8'h01,20'h0,     0,0,8'h00,20'h0, 0,0,0,0,8'h01,20'h0, 0,1,20'h55555);
    // counter cleared by grant, held while host idle
    add(0, 1,0,0,8'h01,20'h0,     1,0,8'h02,20'h0, 0,0,0,0,8'h01,20'h0, 1,0,20'h11111);
    add(0, 1,0,0,8'h01,20'h0,     1,0,8'h02,20'h0, 0,0,0,0,8'h01,20'h0, 1,0,20'h11111);
    add(0, 1,0,0,8'h01,20'h0,     0,0,8'h00,20'h0, 0,0,0,0,8'h01,20'h0, 1,0,20'h11111);
    add(0, 1,0,0,8'h01,20'h0,     1,0,8'h02,20'h0, 0,0,0,0,8'h01,20'h0, 1,0,20'h11111);
    add(0, 1,0,0,8'h01,20'h0,     1,0,8'h02,20'h0, 0,0,0,0,8'h01,20'h0, 1,0,20'h11111);
    add(0, 1,0,0,8'h01,20'h0,     1,0,8'h02,20'h0, 1,1,0,0,8'h02,20'h0, 1,0,20'h11111);
    add(0, 0,0,0,8'h00,20'h0,     0,0,8'h00,20'h0, 0,0,0,0,8'h00,20'h0, 0,1,20'h22222);
    // three lost conflicts, then reset: counter must restart from zero
    add(0, 1,0,0,8'h01,20'h0,     1,0,8'h05,20'h0, 0,0,0,0,8'h01,20'h0, 0,0,20'h0);
    add(0, 1,0,0,8'h01,20'h0,     1,0,8'h05,20'h0, 0,0,0,0,8'h01,20'h0, 1,0,20'h11111);
    add(0, 1,0,0,8'h01,20'h0,     1,0,8'h05,20'h0, 0,0,0,0,8'h01,20'h0, 1,0,20'h11111);
    add(1, 0,1,0,8'h30,20'h77777, 1,0,8'h05,20'h0, 0,0,0,0,8'h00,20'h0, 0,0,20'h0);
    add(0, 1,0,0,8'h01,20'h0,     1,0,8'h05,20'h0, 0,0,0,0,8'h01,20'h0, 0,0,20'h0);
    add(0, 1,0,0,8'h01,20'h0,     1,0,8'h05,20'h0, 0,0,0,0,8'h01,20'h0, 1,0,20'h11111);
    add(0, 1,0,0,8'h01,20'h0,     1,0,8'h05,20'h0, 0,0,0,0,8'h01,20'h0, 1,0,20'h11111);
    add(0, 1,0,0,8'h01,20'h0,     1,0,8'h05,20'h0, 0,0,0,0,8'h01,20'h0, 1,0,20'h11111);
    add(0, 1,0,0,8'h01,20'h0,     1,0,8'h05,20'h0, 1,1,0,0,8'h05,20'h0, 1,0,20'h11111);
    // host read granted, then reset before its data is consumed
    add(0, 0,0,0,8'h00,20'h0,     1,0,8'h05,20'h0, 0,1,0,0,8'h05,20'h0, 0,1,20'h55555);
    add(1, 0,0,0,8'h00,20'h0,     0,0,8'h00,20'h0, 0,0,0,0,8'h00,20'h0, 0,0,20'h0);
    add(0, 0,0,0,8'h00,20'h0,     0,0,8'h00,20'h0, 0,0,0,0,8'h00,20'h0, 0,0,20'h0);
    // nothing was written to 0x30 during reset
    add(0, 1,0,0,8'h30,20'h0,     0,0,8'h00,20'h0, 0,0,0,0,8'h30,20'h0, 0,0,20'h0);
    add(0, 0,0,0,8'h00,20'h0,     0,0,8'h00,20'h0, 0,0,0,0,8'h00,20'h0, 1,0,20'h00000);
    // read+write together: write only, no read response
    add(0, 1,1,0,8'h40,20'h0F0F0, 0,0,8'h00,20'h0, 0,0,1,0,8'h40,20'h0F0F0, 0,0,20'h0);
    add(0, 0,0,0,8'h00,20'h0,     0,0,8'h00,20'h0, 0,0,0,0,8'h00,20'h0, 0,0,20'h0);
    add(0, 1,0,0,8'h40,20'h0,     0,0,8'h00,20'h0, 0,0,0,0,8'h40,20'h0, 0,0,20'h0);
    add(0, 0,0,0,8'h00,20'h0,     0,0,8'h00,20'h0, 0,0,0,0,8'h00,20'h0, 1,0,20'h0F0F0);

    next_cycle();
    mem_init = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i]);
      #4;
      check(i, vecs[i]);
      next_cycle();
    end
    apply(vecs[1]);

    // HOST_MAX_WAIT = 0: host wins every conflict
    rst1 = 1'b0;
    core_write1 = 1; core_addr1 = 8'h30; core_wdata1 = 20'h0C0DE;
    host_req1 = 1; host_we1 = 1; host_addr1 = 8'h30; host_wdata1 = 20'h0A0A0;
    #4;
    chk("w0_host_gnt", 0, 32'(host_gnt1), 32'd1);
    chk("w0_core_stall", 0, 32'(core_stall1), 32'd1);
    chk("w0_mem_we", 0, 32'(mem_we1), 32'd1);
    chk("w0_mem_wdata", 0, 32'(mem_wdata1), 32'h0A0A0);
    chk("w0_mem_byte_en", 0, 32'(mem_byte_en1), 32'd0);
    next_cycle();
    host_req1 = 0; host_we1 = 0;
    #4;
    chk("w0_core_stall", 1, 32'(core_stall1), 32'd0);
    chk("w0_host_gnt", 1, 32'(host_gnt1), 32'd0);
    chk("w0_mem_we", 1, 32'(mem_we1), 32'd1);
    chk("w0_mem_wdata", 1, 32'(mem_wdata1), 32'h0C0DE);
    next_cycle();
    core_write1 = 0; core_read1 = 1;
    #4;
    chk("w0_core_stall", 2, 32'(core_stall1), 32'd0);
    next_cycle();
    core_read1 = 0;
    #4;
    chk("w0_core_rvalid", 3, 32'(core_rvalid1), 32'd1);
    chk("w0_core_rdata", 3, 32'(core_rdata1), 32'h0C0DE);
    next_cycle();
    core_read1 = 1; host_req1 = 1; host_we1 = 0;
    #4;
    chk("w0_host_gnt", 4, 32'(host_gnt1), 32'd1);
    chk("w0_core_stall", 4, 32'(core_stall1), 32'd1);
    chk("w0_core_rvalid", 4, 32'(core_rvalid1), 32'd0);
    next_cycle();
    core_read1 = 0; host_req1 = 0;
    #4;
    chk("w0_host_rvalid", 5, 32'(host_rvalid1), 32'd1);
    chk("w0_host_rdata", 5, 32'(host_rdata1), 32'h0C0DE);
    chk("w0_core_rvalid", 5, 32'(core_rvalid1), 32'd0);
    next_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
